// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 800x600@60 timing constants, counter width and monitor state encoding
package vga_timing_pkg;
  localparam int CW = 11;
  localparam int VGA_H_TOTAL = 1056;
  localparam int VGA_V_TOTAL = 628;
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_H_SYNC_START = 840;
  localparam int VGA_H_SYNC_END = 967;
  localparam int VGA_V_SYNC_START = 601;
  localparam int VGA_V_SYNC_END = 604;
  localparam int VGA_LOCK_FRAMES = 2;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} mon_state_e;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_bus_t;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers the timing bus, keeps the previous sample and decodes frame start
module vga_sync_edge
  import vga_timing_pkg::*;
(
  input  logic     pclk,
  input  logic     rst,
  input  logic     hsync,
  input  logic     vsync,
  input  logic     hblnk,
  input  logic     vblnk,
  output vga_bus_t s,
  output logic     sof
);
  vga_bus_t s_q, s_d, d_q, d_d;
  // next current/previous samples
  always_comb begin
    s_d = '{hsync: hsync, vsync: vsync, hblnk: hblnk, vblnk: vblnk};
    d_d = s_q;
  end
  // sample registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      s_q <= '0;
      d_q <= '0;
    end else begin
      s_q <= s_d;
      d_q <= d_d;
    end
  end
  assign s = s_q;
  assign sof = d_q.vblnk & d_q.hblnk & ~s_q.vblnk & ~s_q.hblnk;
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: rebuilds and checks VGA timing, locks after clean frames (stats under VGA_MON_STATS_EN)
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int H_SYNC_END = VGA_H_SYNC_END,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int V_SYNC_END = VGA_V_SYNC_END,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          hblnk,
  input  logic          vblnk,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] hcount_rec,
  output logic [CW-1:0] vcount_rec,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    err_cnt
);
  vga_bus_t s, exp_bus;
  logic sof, hlast, vlast, wrap, mis, lock_now;
  logic [CW-1:0] h_q, h_d, v_q, v_d, h_step, v_step, hrec_q, hrec_d, vrec_q, vrec_d;
  logic [3:0] clean_q, clean_d;
  logic err_q, err_d, locked_q, locked_d;
  mon_state_e state_q, state_d;

  vga_sync_edge u_edge (
    .pclk (pclk),
    .rst  (rst),
    .hsync(hsync),
    .vsync(vsync),
    .hblnk(hblnk),
    .vblnk(vblnk),
    .s    (s),
    .sof  (sof)
  );

  // expected levels at (h, v), mismatch detect and counter step
  always_comb begin
    hlast = h_q == CW'(H_TOTAL - 1);
    vlast = v_q == CW'(V_TOTAL - 1);
    wrap = hlast & vlast;
    exp_bus.hsync = (h_q >= CW'(H_SYNC_START)) && (h_q <= CW'(H_SYNC_END));
    exp_bus.vsync = (v_q >= CW'(V_SYNC_START)) && (v_q <= CW'(V_SYNC_END));
    exp_bus.hblnk = h_q >= CW'(H_ACTIVE);
    exp_bus.vblnk = v_q >= CW'(V_ACTIVE);
    mis = (state_q != SEARCH) && (s != exp_bus);
    lock_now = (state_q == LOCKED) && !mis;
    h_step = hlast ? '0 : h_q + 1'b1;
    v_step = hlast ? (vlast ? '0 : v_q + 1'b1) : v_q;
  end

  // state machine, position tracking and registered outputs
  always_comb begin
    state_d = state_q;
    h_d = h_step;
    v_d = v_step;
    clean_d = clean_q;
    if (state_q == SEARCH) begin
      state_d = sof ? TRACK : SEARCH;
      h_d = sof ? CW'(1) : '0;
      v_d = '0;
      clean_d = '0;
    end else if (mis) begin
      state_d = SEARCH;
      h_d = '0;
      v_d = '0;
      clean_d = '0;
    end else if (state_q == TRACK && wrap) begin
      clean_d = clean_q + 4'd1;
      state_d = (clean_q + 4'd1 == 4'(LOCK_FRAMES)) ? LOCKED : TRACK;
    end
    err_d = mis;
    locked_d = lock_now;
    hrec_d = lock_now ? h_q : '0;
    vrec_d = lock_now ? v_q : '0;
  end

  // monitor registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= SEARCH;
      h_q <= '0;
      v_q <= '0;
      clean_q <= '0;
      err_q <= 1'b0;
      locked_q <= 1'b0;
      hrec_q <= '0;
      vrec_q <= '0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      v_q <= v_d;
      clean_q <= clean_d;
      err_q <= err_d;
      locked_q <= locked_d;
      hrec_q <= hrec_d;
      vrec_q <= vrec_d;
    end
  end

  assign err = err_q;
  assign locked = locked_q;
  assign hcount_rec = hrec_q;
  assign vcount_rec = vrec_q;

`ifdef VGA_MON_STATS_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic [7:0] ecnt_q, ecnt_d;
  // locked frame count wraps, error count saturates
  always_comb begin
    fcnt_d = fcnt_q + 16'(lock_now & wrap);
    ecnt_d = ecnt_q + 8'(mis && ecnt_q != 8'hff);
  end
  // statistics registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      ecnt_q <= ecnt_d;
    end
  end
  assign frame_cnt = fcnt_q;
  assign err_cnt = ecnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed checks of lock, glitch recovery, reset, wrap and wrong geometry
module tb_vga_timing_monitor;
  localparam int HT = 16, VT = 8, HA = 10, VA = 5, HS0 = 11, HS1 = 13, VS0 = 6, VS1 = 6, LF = 2;
  localparam int F = HT * VT;
`ifdef VGA_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic pclk = 1'b0, rst = 1'b1;
  logic hsync = 1'b0, vsync = 1'b0, hblnk = 1'b0, vblnk = 1'b0;
  logic locked, err;
  logic [10:0] hcount_rec, vcount_rec;
  logic [15:0] frame_cnt, fc;
  logic [7:0] err_cnt;
  int checks = 0, failures = 0;
  int sh = 0, sv = 0, htot = HT, p1h = 0, p1v = 0, p2h = 0, p2v = 0, pulses = 0;
  logic glitch = 1'b0;

  vga_timing_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_START(HS0), .H_SYNC_END(HS1), .V_SYNC_START(VS0), .V_SYNC_END(VS1),
    .LOCK_FRAMES(LF)
  ) dut (
    .pclk(pclk), .rst(rst), .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
    .locked(locked), .err(err), .hcount_rec(hcount_rec), .vcount_rec(vcount_rec),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    hsync = ((sh >= HS0) && (sh <= HS1)) ^ glitch;
    vsync = (sv >= VS0) && (sv <= VS1);
    hblnk = sh >= HA;
    vblnk = sv >= VA;
    @(posedge pclk);
    #1;
    p2h = p1h; p2v = p1v; p1h = sh; p1v = sv;
    glitch = 1'b0;
    if (sh >= htot - 1) begin
      sh = 0;
      sv = (sv == VT - 1) ? 0 : sv + 1;
    end else sh = sh + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic go_to(input int h, input int v);
    for (int n = 0; n < 4 * F && !(sh == h && sv == v); n++) tick();
  endtask

  task automatic relock(input string tag);
    go_to(0, 0);
    for (int i = 0; i < 2 * F + 1; i++) begin
      tick();
      chk({tag, "_unlocked"}, locked, 0);
      chk({tag, "_err_quiet"}, err, 0);
    end
    tick();
    chk({tag, "_locked"}, locked, 1);
    chk({tag, "_hrec0"}, hcount_rec, 0);
    chk({tag, "_vrec0"}, vcount_rec, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_hrec", hcount_rec, 0);
    chk("rst_vrec", vcount_rec, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    sh = 0; sv = 0;
    for (int i = 0; i < F; i++) begin
      tick();
      chk("first_frame_unlocked", locked, 0);
      chk("first_frame_hrec", hcount_rec, 0);
    end
    relock("clean");
    fc = 0;
    for (int i = 0; i < 10 * F; i++) begin
      tick();
      chk("run_locked", locked, 1);
      chk("run_err", err, 0);
      chk("run_hrec", hcount_rec, p2h);
      chk("run_vrec", vcount_rec, p2v);
      if (p1h == HT - 1 && p1v == VT - 1) fc = frame_cnt;
      if (p2h == 0 && p2v == 0) chk("run_frame_inc", frame_cnt, STATS ? fc + 16'd1 : 16'd0);
    end
    chk("run_frame_total", frame_cnt, STATS ? 10 : 0);
    go_to(5, 3);
    glitch = 1'b1;
    tick();
    chk("glitch_err_lat", err, 0);
    chk("glitch_still_locked", locked, 1);
    tick();
    chk("glitch_err", err, 1);
    chk("glitch_unlock", locked, 0);
    chk("glitch_hrec", hcount_rec, 0);
    tick();
    chk("glitch_err_1cyc", err, 0);
    relock("glitch");
    chk("glitch_err_cnt", err_cnt, STATS ? 1 : 0);
    go_to(HT - 1, VT - 1);
    tick();
    fc = frame_cnt;
    tick();
    tick();
    chk("wrap_hrec", hcount_rec, 0);
    chk("wrap_vrec", vcount_rec, 0);
    chk("wrap_frame_inc", frame_cnt, STATS ? fc + 16'd1 : 16'd0);
    go_to(8, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_locked", locked, 0);
    chk("midrst_hrec", hcount_rec, 0);
    chk("midrst_vrec", vcount_rec, 0);
    chk("midrst_err", err, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    relock("midrst");
    rst = 1'b1;
    htot = HT - 1;
    tick();
    rst = 1'b0;
    sh = 0; sv = 0;
    pulses = 0;
    for (int i = 0; i < 262 * (HT - 1) * VT; i++) begin
      tick();
      chk("geom_unlocked", locked, 0);
      if (err === 1'b1) pulses++;
    end
    chk("geom_pulses", pulses, 261);
    chk("geom_err_sat", err_cnt, STATS ? 255 : 0);
    for (int i = 0; i < 2 * (HT - 1) * VT; i++) tick();
    chk("geom_err_hold", err_cnt, STATS ? 255 : 0);
    chk("geom_still_unlocked", locked, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
